// File: rtl/reg_arbiter.sv
// Register bank shared between an SPI port (never stalled) and a core port (req/gnt handshake).
module reg_arbiter #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned REG_W  = 8
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          ena,
    input  logic [ADDR_W-1:0]             spi_addr,
    input  logic [REG_W-1:0]              spi_wdata,
    input  logic                          spi_wr,
    output logic [REG_W-1:0]              spi_rdata,
    input  logic                          core_req,
    input  logic                          core_we,
    input  logic [ADDR_W-1:0]             core_addr,
    input  logic [REG_W-1:0]              core_wdata,
    output logic                          core_gnt,
    output logic [REG_W-1:0]              core_rdata,
    input  logic                          clr_stats,
    output logic [7:0]                    stall_cnt,
    output logic [REG_W*(2**ADDR_W)-1:0]  regs_o
);

    localparam int unsigned DEPTH    = 2**ADDR_W;
    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             core_acc_c;
    logic             stall_c;
    logic [REG_W-1:0] regs_q [DEPTH];

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: SPI wins over the core in IDLE; ACK lasts exactly one enabled cycle
    always_comb begin
        state_d    = state_q;
        core_acc_c = 1'b0;
        stall_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena && core_req) begin
                    if (spi_wr) begin
                        stall_c = 1'b1;
                    end else begin
                        core_acc_c = 1'b1;
                        state_d    = ACK;
                    end
                end
            end
            ACK: begin
                if (ena) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is the ACK state itself, suppressed while the block is disabled
    assign core_gnt = (state_q == ACK) && ena;

    // Register bank: a core access only happens when no SPI write is present
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (ena) begin
            if (spi_wr) begin
                regs_q[spi_addr] <= spi_wdata;
            end else if (core_acc_c && core_we) begin
                regs_q[core_addr] <= core_wdata;
            end
        end
    end

    // Read-data capture; both read the pre-edge bank contents
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            spi_rdata  <= '0;
            core_rdata <= '0;
        end else if (ena) begin
            spi_rdata <= regs_q[spi_addr];
            if (core_acc_c && !core_we) begin
                core_rdata <= regs_q[core_addr];
            end
        end
    end

    // Saturating stall counter; clear beats increment
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stall_cnt <= '0;
        end else if (ena) begin
            if (clr_stats) begin
                stall_cnt <= '0;
            end else if (stall_c && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Flattened bank view
    for (genvar g = 0; g < DEPTH; g++) begin : g_regs_o
        assign regs_o[g*REG_W +: REG_W] = regs_q[g];
    end

endmodule

// File: tb/tb_reg_arbiter.sv
// Self-checking bench for reg_arbiter: reference bank model plus a read-data scoreboard.
module tb_reg_arbiter;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned REG_W  = 8;
    localparam int unsigned DEPTH  = 2**ADDR_W;

    logic                        clk = 1'b0;
    logic                        rstb;
    logic                        ena;
    logic [ADDR_W-1:0]           spi_addr;
    logic [REG_W-1:0]            spi_wdata;
    logic                        spi_wr;
    logic [REG_W-1:0]            spi_rdata;
    logic                        core_req;
    logic                        core_we;
    logic [ADDR_W-1:0]           core_addr;
    logic [REG_W-1:0]            core_wdata;
    logic                        core_gnt;
    logic [REG_W-1:0]            core_rdata;
    logic                        clr_stats;
    logic [7:0]                  stall_cnt;
    logic [REG_W*DEPTH-1:0]      regs_o;

    logic [REG_W-1:0] mdl [DEPTH];
    logic [REG_W-1:0] exp_q [$];
    logic [REG_W-1:0] last_rd;
    logic [7:0]       exp_stall;
    int               n_cmp = 0;
    int               n_err = 0;

    reg_arbiter #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .ena        (ena),
        .spi_addr   (spi_addr),
        .spi_wdata  (spi_wdata),
        .spi_wr     (spi_wr),
        .spi_rdata  (spi_rdata),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rdata (core_rdata),
        .clr_stats  (clr_stats),
        .stall_cnt  (stall_cnt),
        .regs_o     (regs_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [REG_W*DEPTH-1:0] packed_model();
        logic [REG_W*DEPTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i*REG_W +: REG_W] = mdl[i];
        return v;
    endfunction

    task automatic test_reset();
        rstb = 1'b0; ena = 1'b1; spi_addr = '0; spi_wdata = '0; spi_wr = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; clr_stats = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        last_rd = '0; exp_stall = '0;
        #22;
        n_cmp++; if (regs_o !== '0) begin n_err++; $display("FAIL reset_regs: got %h want 0", regs_o); end
        n_cmp++; if (core_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", core_gnt); end
        n_cmp++; if (stall_cnt !== 8'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        n_cmp++; if ({spi_rdata, core_rdata} !== '0) begin n_err++; $display("FAIL reset_rdata: got %h/%h want 0/0", spi_rdata, core_rdata); end
        #1 rstb = 1'b1;
        tick();
    endtask

    task automatic test_spi_write();
        spi_addr = 3'd3; spi_wdata = 8'hA5; spi_wr = 1'b1;
        tick();
        spi_wr = 1'b0; mdl[3] = 8'hA5;
        n_cmp++; if (regs_o[3*REG_W +: REG_W] !== 8'hA5) begin n_err++; $display("FAIL spi_wr_reg3: got %h want a5", regs_o[3*REG_W +: REG_W]); end
        n_cmp++; if (spi_rdata !== 8'h00) begin n_err++; $display("FAIL spi_rdata_rbw: got %h want 00", spi_rdata); end
        tick();
        n_cmp++; if (spi_rdata !== 8'hA5) begin n_err++; $display("FAIL spi_rdata: got %h want a5", spi_rdata); end
    endtask

    task automatic test_core_access();
        bit got;
        core_req = 1'b1; core_we = 1'b1; core_addr = 3'd5; core_wdata = 8'h3C;
        tick();
        mdl[5] = 8'h3C;
        n_cmp++; if (core_gnt !== 1'b1) begin n_err++; $display("FAIL core_wr_gnt: got %b want 1", core_gnt); end
        n_cmp++; if (regs_o[5*REG_W +: REG_W] !== 8'h3C) begin n_err++; $display("FAIL core_wr_reg5: got %h want 3c", regs_o[5*REG_W +: REG_W]); end
        n_cmp++; if (core_rdata !== last_rd) begin n_err++; $display("FAIL core_wr_rdata_hold: got %h want %h", core_rdata, last_rd); end
        core_req = 1'b0;
        tick();
        n_cmp++; if (core_gnt !== 1'b0) begin n_err++; $display("FAIL core_gnt_pulse: got %b want 0", core_gnt); end
        core_req = 1'b1; core_we = 1'b0; core_addr = 3'd5;
        exp_q.push_back(mdl[5]);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (core_gnt) begin
                logic [REG_W-1:0] e;
                got = 1'b1; e = exp_q.pop_front(); last_rd = e;
                n_cmp++; if (core_rdata !== e) begin n_err++; $display("FAIL core_rd_data: got %h want %h", core_rdata, e); end
            end
        end
        n_cmp++; if (!got) begin n_err++; $display("FAIL core_rd_timeout: got no gnt want gnt"); end
        core_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [REG_W-1:0] e;
        core_req = 1'b1; core_we = 1'b0; core_addr = 3'd3;
        exp_q.push_back(mdl[3]);
        tick();
        n_cmp++; if (core_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt1: got %b want 1", core_gnt); end
        if (core_gnt) begin
            e = exp_q.pop_front(); last_rd = e;
            n_cmp++; if (core_rdata !== e) begin n_err++; $display("FAIL b2b_rd1: got %h want %h", core_rdata, e); end
        end
        core_addr = 3'd5; exp_q.push_back(mdl[5]);
        spi_addr = 3'd1; spi_wdata = 8'h11; spi_wr = 1'b1;
        tick();
        mdl[1] = 8'h11; spi_wr = 1'b0;
        n_cmp++; if (core_gnt !== 1'b0) begin n_err++; $display("FAIL b2b_ack_ignores_req: got %b want 0", core_gnt); end
        tick();
        n_cmp++; if (core_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt2: got %b want 1", core_gnt); end
        if (core_gnt) begin
            e = exp_q.pop_front(); last_rd = e;
            n_cmp++; if (core_rdata !== e) begin n_err++; $display("FAIL b2b_rd2: got %h want %h", core_rdata, e); end
        end
        n_cmp++; if (regs_o[1*REG_W +: REG_W] !== 8'h11) begin n_err++; $display("FAIL spi_wr_in_ack: got %h want 11", regs_o[1*REG_W +: REG_W]); end
        core_req = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        core_req = 1'b1; core_we = 1'b1; core_addr = 3'd2; core_wdata = 8'h77;
        for (int k = 0; k < 3; k++) begin
            spi_addr = 3'd0; spi_wdata = 8'(k + 1); spi_wr = 1'b1;
            tick();
            mdl[0] = 8'(k + 1); exp_stall++;
            n_cmp++; if (core_gnt !== 1'b0) begin n_err++; $display("FAIL stall_no_gnt[%0d]: got %b want 0", k, core_gnt); end
        end
        n_cmp++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL stall_cnt3: got %0d want %0d", stall_cnt, exp_stall); end
        spi_wr = 1'b0;
        tick();
        mdl[2] = 8'h77;
        n_cmp++; if (core_gnt !== 1'b1) begin n_err++; $display("FAIL stall_release_gnt: got %b want 1", core_gnt); end
        n_cmp++; if (regs_o !== packed_model()) begin n_err++; $display("FAIL stall_regs: got %h want %h", regs_o, packed_model()); end
        n_cmp++; if (core_rdata !== last_rd) begin n_err++; $display("FAIL wr_gnt_rdata_hold: got %h want %h", core_rdata, last_rd); end
        core_req = 1'b0;
        tick();
    endtask

    task automatic test_saturate_clear();
        int gnts = 0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 3'd6; core_wdata = 8'h66;
        spi_addr = 3'd0; spi_wr = 1'b1;
        for (int k = 0; k < 300; k++) begin
            spi_wdata = 8'(k);
            tick();
            mdl[0] = 8'(k);
            if (exp_stall != 8'hFF) exp_stall++;
            if (core_gnt) gnts++;
        end
        n_cmp++; if (stall_cnt !== 8'd255) begin n_err++; $display("FAIL stall_saturate: got %0d want 255", stall_cnt); end
        n_cmp++; if (gnts !== 0) begin n_err++; $display("FAIL stall_gnts: got %0d want 0", gnts); end
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0; exp_stall = 8'd0;
        n_cmp++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL clr_beats_inc: got %0d want 0", stall_cnt); end
        tick();
        exp_stall = 8'd1;
        n_cmp++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL stall_after_clr: got %0d want 1", stall_cnt); end
        spi_wr = 1'b0;
        tick();
        mdl[6] = 8'h66;
        n_cmp++; if (core_gnt !== 1'b1) begin n_err++; $display("FAIL sat_release_gnt: got %b want 1", core_gnt); end
        n_cmp++; if (regs_o !== packed_model()) begin n_err++; $display("FAIL sat_regs: got %h want %h", regs_o, packed_model()); end
        core_req = 1'b0;
        tick();
    endtask

    task automatic test_ena_low();
        int gnts = 0;
        ena = 1'b0;
        spi_addr = 3'd4; spi_wdata = 8'hEE; spi_wr = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 3'd7; core_wdata = 8'h99; clr_stats = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (core_gnt !== 1'b0) gnts++;
        end
        n_cmp++; if (gnts !== 0) begin n_err++; $display("FAIL ena_low_gnt: got %0d gnts want 0", gnts); end
        n_cmp++; if (regs_o !== packed_model()) begin n_err++; $display("FAIL ena_low_regs: got %h want %h", regs_o, packed_model()); end
        n_cmp++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL ena_low_stall: got %0d want %0d", stall_cnt, exp_stall); end
        ena = 1'b1; spi_wr = 1'b0; core_req = 1'b0; clr_stats = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_ack();
        int gnts = 0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 3'd2;
        tick();
        n_cmp++; if (core_gnt !== 1'b1) begin n_err++; $display("FAIL rst_ack_gnt: got %b want 1", core_gnt); end
        n_cmp++; if (core_rdata !== mdl[2]) begin n_err++; $display("FAIL rst_ack_rdata: got %h want %h", core_rdata, mdl[2]); end
        rstb = 1'b0; core_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        exp_stall = '0;
        #1;
        n_cmp++; if (core_gnt !== 1'b0) begin n_err++; $display("FAIL rst_gnt_now: got %b want 0", core_gnt); end
        n_cmp++; if (regs_o !== '0) begin n_err++; $display("FAIL rst_regs: got %h want 0", regs_o); end
        n_cmp++; if ({stall_cnt, spi_rdata, core_rdata} !== '0) begin n_err++; $display("FAIL rst_misc: got %h want 0", {stall_cnt, spi_rdata, core_rdata}); end
        #3 rstb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (core_gnt !== 1'b0) gnts++;
        end
        n_cmp++; if (gnts !== 0) begin n_err++; $display("FAIL rst_no_late_gnt: got %0d want 0", gnts); end
        core_req = 1'b1; core_we = 1'b1; core_addr = 3'd4; core_wdata = 8'h5A;
        tick();
        mdl[4] = 8'h5A;
        n_cmp++; if (core_gnt !== 1'b1) begin n_err++; $display("FAIL rst_idle_gnt: got %b want 1", core_gnt); end
        n_cmp++; if (regs_o !== packed_model()) begin n_err++; $display("FAIL rst_post_regs: got %h want %h", regs_o, packed_model()); end
        core_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_spi_write();
        test_core_access();
        test_back_to_back();
        test_stall();
        test_saturate_clear();
        test_ena_low();
        test_reset_in_ack();
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 3: register address width; bank depth is 2**ADDR_W.
REQ-002 SHALL have parameter REG_W, default 8: register data width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstb, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port ena, input, 1: global enable; when low, all state holds.
REQ-006 SHALL have port spi_addr, input, ADDR_W: SPI-side register address.
REQ-007 SHALL have port spi_wdata, input, REG_W: SPI-side write data.
REQ-008 SHALL have port spi_wr, input, 1: SPI write strobe, 1-cycle pulse, never stallable.
REQ-009 SHALL have port spi_rdata, output, REG_W: registered readback of reg[spi_addr].
REQ-010 SHALL have port core_req, input, 1: core access request, held until core_gnt.
REQ-011 SHALL have port core_we, input, 1: core access type; 1 = write, 0 = read.
REQ-012 SHALL have port core_addr, input, ADDR_W: core address.
REQ-013 SHALL have port core_wdata, input, REG_W: core write data.
REQ-014 SHALL have port core_gnt, output, 1: 1-cycle access-complete pulse.
REQ-015 SHALL have port core_rdata, output, REG_W: read data, valid while core_gnt=1.
REQ-016 SHALL have port clr_stats, input, 1: synchronous clear of stall_cnt.
REQ-017 SHALL have port stall_cnt, output, 8: saturating count of core stall cycles.
REQ-018 SHALL have port regs_o, output, REG_W*2**ADDR_W: flattened bank contents; reg[i] at bits [i*REG_W +: REG_W].

Function
REQ-019 SHALL hold 2**ADDR_W registers of REG_W bits, shared between the SPI side and the core side.
REQ-020 SHALL, while ena=0, hold all state, keep core_gnt=0, and ignore spi_wr, core_req and clr_stats.
REQ-021 SHALL, when spi_wr=1 at edge N, write spi_wdata to reg[spi_addr] at edge N, visible on regs_o in cycle N+1.
REQ-022 SHALL implement FSM states IDLE and ACK.
REQ-023 SHALL move IDLE->ACK when core_req=1 and spi_wr=0, performing the core access at that edge.
REQ-024 SHALL, for a core write, update reg[core_addr] with core_wdata at the IDLE->ACK edge.
REQ-025 SHALL, for a core read, capture reg[core_addr] into core_rdata at the IDLE->ACK edge.
REQ-026 SHALL drive core_gnt=1 exactly in ACK and move ACK->IDLE unconditionally after one cycle.
REQ-027 SHALL ignore core_req in ACK; core throughput is at most one access per 2 cycles.
REQ-028 SHALL give SPI priority: in IDLE with core_req=1 and spi_wr=1, perform the SPI write only and stay in IDLE.
REQ-029 SHALL accept spi_wr in ACK, with the SPI write taking effect normally.
REQ-030 SHALL increment stall_cnt by 1 for each enabled cycle meeting REQ-028, saturating at 255.
REQ-031 SHALL clear stall_cnt on clr_stats=1; clear takes precedence over a simultaneous increment.
REQ-032 SHALL register spi_rdata <= reg[spi_addr] every enabled cycle, read-before-write (a same-edge write appears one cycle later).
REQ-033 SHALL hold core_rdata between grants; write grants leave core_rdata unchanged.

Reset
REQ-034 SHALL, on rstb=0, asynchronously clear all registers, spi_rdata, core_rdata and stall_cnt to 0, set core_gnt=0 and the state to IDLE.
REQ-035 SHALL abandon any in-flight ACK on reset mid-operation, with no gnt pulse issued after reset release.

Verification
REQ-036 SHALL pass: SPI write addr 3 data 0xA5 -> regs_o reg[3]=0xA5 next cycle; spi_rdata=0xA5 one cycle after that.
REQ-037 SHALL pass: core write addr 5 data 0x3C with no spi_wr -> core_gnt pulses one cycle later; core read addr 5 -> core_rdata=0x3C with gnt.
REQ-038 SHALL pass: core_req with spi_wr high for 3 consecutive cycles -> no gnt during those cycles, stall_cnt=3, gnt 1 cycle after spi_wr drops.
REQ-039 SHALL pass: 300 stall cycles -> stall_cnt=255; clr_stats coinciding with a stall -> stall_cnt=0.
REQ-040 SHALL pass: ena=0 during spi_wr and core_req -> no register change, no gnt, stall_cnt unchanged.
REQ-041 SHALL pass: rstb asserted during ACK -> core_gnt=0 immediately, all regs 0, state IDLE.
